// File: rtl/stager_defs.sv
// Shared constants for the operand stager: FSM encoding and pair counter width.
package stager_defs;

  typedef enum logic [1:0] {
    LOAD_X  = 2'b00,
    LOAD_Y  = 2'b01,
    PRESENT = 2'b10
  } stager_state_t;

  localparam int PAIR_COUNT_W = 8;

endpackage

// File: rtl/operand_stager_reg_en_n.sv
// N-bit loadable register with asynchronous active-low clear.
module reg_en_n #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/operand_stager.sv
// Collects two operand words (X then Y, with select on Y) from a valid/ready
// bus and presents them as one complete pair to a downstream 2:1 mux.
module operand_stager
  import stager_defs::*;
#(
  parameter int N = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N-1:0]            in_data,
  input  logic                    in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [N-1:0]            X,
  output logic [N-1:0]            Y,
  output logic                    S,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [PAIR_COUNT_W-1:0] pair_count
);

  stager_state_t           state_reg;
  logic                    in_ready_reg;
  logic                    out_valid_reg;
  logic [PAIR_COUNT_W-1:0] pair_count_reg;
  logic                    x_en;
  logic                    y_en;

  // in_ready is high exactly in the load states, so the state alone qualifies a transfer.
  assign x_en = (state_reg == LOAD_X) && in_valid;
  assign y_en = (state_reg == LOAD_Y) && in_valid;

  // Handshake outputs are registered alongside the state so neither depends on in_valid/out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= LOAD_X;
      in_ready_reg   <= 1'b1;
      out_valid_reg  <= 1'b0;
      pair_count_reg <= '0;
    end else begin
      case (state_reg)
        LOAD_X: begin
          if (in_valid) begin
            state_reg <= LOAD_Y;
          end
        end
        LOAD_Y: begin
          if (in_valid) begin
            state_reg     <= PRESENT;
            in_ready_reg  <= 1'b0;
            out_valid_reg <= 1'b1;
          end
        end
        PRESENT: begin
          if (out_ready) begin
            state_reg      <= LOAD_X;
            in_ready_reg   <= 1'b1;
            out_valid_reg  <= 1'b0;
            pair_count_reg <= pair_count_reg + 1'b1;
          end
        end
        default: begin
          state_reg     <= LOAD_X;
          in_ready_reg  <= 1'b1;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  reg_en_n #(.N(N)) u_reg_x (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (x_en),
    .d     (in_data),
    .q     (X)
  );

  reg_en_n #(.N(N)) u_reg_y (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (y_en),
    .d     (in_data),
    .q     (Y)
  );

  reg_en_n #(.N(1)) u_reg_s (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (y_en),
    .d     (in_sel),
    .q     (S)
  );

  assign in_ready   = in_ready_reg;
  assign out_valid  = out_valid_reg;
  assign pair_count = pair_count_reg;

endmodule

// File: tb/tb_operand_stager.sv
// Directed bench for operand_stager: vector table plus reset, gap and wrap sequences.
module tb_operand_stager;

  localparam int N = 32;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] in_data;
  logic         in_sel;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] X;
  logic [N-1:0] Y;
  logic         S;
  logic         out_valid;
  logic         out_ready;
  logic [7:0]   pair_count;

  int checks = 0;
  int errors = 0;

  operand_stager #(.N(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .X          (X),
    .Y          (Y),
    .S          (S),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .pair_count (pair_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         v;
    logic [N-1:0] d;
    logic         sel;
    logic         ordy;
    logic         e_ir;
    logic         e_ov;
    logic [N-1:0] e_x;
    logic [N-1:0] e_y;
    logic         e_s;
    logic [7:0]   e_cnt;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic ir, input logic ov,
                         input logic [N-1:0] ex, input logic [N-1:0] ey,
                         input logic es, input logic [7:0] ecnt);
    chk({tag, ".in_ready"}, N'(in_ready), N'(ir));
    chk({tag, ".out_valid"}, N'(out_valid), N'(ov));
    chk({tag, ".X"}, X, ex);
    chk({tag, ".Y"}, Y, ey);
    chk({tag, ".S"}, N'(S), N'(es));
    chk({tag, ".pair_count"}, N'(pair_count), N'(ecnt));
  endtask

  task automatic drive(input logic v, input logic [N-1:0] d, input logic sel, input logic ordy);
    in_valid  = v;
    in_data   = d;
    in_sel    = sel;
    out_ready = ordy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(logic v, logic [N-1:0] d, logic sel, logic ordy, logic ir, logic ov,
                              logic [N-1:0] ex, logic [N-1:0] ey, logic es, logic [7:0] ecnt);
    vec_t r;
    r.v = v; r.d = d; r.sel = sel; r.ordy = ordy;
    r.e_ir = ir; r.e_ov = ov; r.e_x = ex; r.e_y = ey; r.e_s = es; r.e_cnt = ecnt;
    return r;
  endfunction

  task automatic pulse_reset();
    #3;
    rst_n = 1'b0;
    #1;
  endtask

  initial begin
    int pulses;
    logic [N-1:0] z;

    // Basic pair, out_ready ignored outside PRESENT, gaps, then 5-cycle backpressure.
    vecs[0]  = mk(1, 32'h0000_00AA, 0, 0, 1, 0, 32'hAA, 32'h0, 0, 8'd0);
    vecs[1]  = mk(1, 32'h0000_0055, 1, 1, 0, 1, 32'hAA, 32'h55, 1, 8'd0);
    vecs[2]  = mk(1, 32'h0000_DEAD, 0, 1, 1, 0, 32'hAA, 32'h55, 1, 8'd1);
    vecs[3]  = mk(0, 32'h0000_1111, 1, 1, 1, 0, 32'hAA, 32'h55, 1, 8'd1);
    vecs[4]  = mk(1, 32'h1234_5678, 1, 0, 1, 0, 32'h1234_5678, 32'h55, 1, 8'd1);
    vecs[5]  = mk(0, 32'h0000_0000, 0, 1, 1, 0, 32'h1234_5678, 32'h55, 1, 8'd1);
    vecs[6]  = mk(0, 32'hFFFF_FFFF, 1, 1, 1, 0, 32'h1234_5678, 32'h55, 1, 8'd1);
    vecs[7]  = mk(1, 32'h9ABC_DEF0, 0, 0, 0, 1, 32'h1234_5678, 32'h9ABC_DEF0, 0, 8'd1);
    for (int i = 8; i < 13; i++)
      vecs[i] = mk(1, 32'h0000_DEAD, 1, 0, 0, 1, 32'h1234_5678, 32'h9ABC_DEF0, 0, 8'd1);
    vecs[13] = mk(1, 32'h0000_DEAD, 1, 1, 1, 0, 32'h1234_5678, 32'h9ABC_DEF0, 0, 8'd2);
    vecs[14] = mk(1, 32'h0000_DEAD, 0, 0, 1, 0, 32'h0000_DEAD, 32'h9ABC_DEF0, 0, 8'd2);

    drive(0, '0, 0, 0);
    rst_n = 1'b1;
    #1;
    rst_n = 1'b0;
    #2;
    chk_all("reset_no_edge", 1, 0, 32'h0, 32'h0, 0, 8'd0);
    step();
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].v, vecs[i].d, vecs[i].sel, vecs[i].ordy);
      step();
      $display("vec %0d: v=%0b d=0x%0h sel=%0b ordy=%0b -> ir=%0b ov=%0b X=0x%0h Y=0x%0h S=%0b cnt=%0d",
               i, vecs[i].v, vecs[i].d, vecs[i].sel, vecs[i].ordy,
               in_ready, out_valid, X, Y, S, pair_count);
      chk_all($sformatf("vec%0d", i), vecs[i].e_ir, vecs[i].e_ov, vecs[i].e_x,
              vecs[i].e_y, vecs[i].e_s, vecs[i].e_cnt);
      if (i == 1) begin
        z = S ? Y : X;
        chk("mux_z", z, 32'h55);
      end
    end

    // Asynchronous reset between edges while in LOAD_Y.
    pulse_reset();
    $display("reset in LOAD_Y: ir=%0b ov=%0b X=0x%0h cnt=%0d", in_ready, out_valid, X, pair_count);
    chk_all("reset_load_y", 1, 0, 32'h0, 32'h0, 0, 8'd0);
    drive(0, '0, 0, 0);
    step();
    rst_n = 1'b1;

    // First word accepted on the first edge after release, then reset discards it.
    drive(1, 32'h0000_0111, 0, 0);
    step();
    chk("first_after_release.X", X, 32'h111);
    pulse_reset();
    chk_all("reset_mid_pair", 1, 0, 32'h0, 32'h0, 0, 8'd0);
    step();
    rst_n = 1'b1;
    drive(1, 32'h0000_0222, 0, 0);
    step();
    drive(1, 32'h0000_0333, 1, 0);
    step();
    chk_all("fresh_pair", 0, 1, 32'h222, 32'h333, 1, 8'd0);
    drive(0, '0, 0, 1);
    step();
    $display("fresh pair consumed: cnt=%0d", pair_count);
    chk_all("fresh_consumed", 1, 0, 32'h222, 32'h333, 1, 8'd1);

    // Reset while a pair is pending in PRESENT.
    drive(1, 32'h0000_0444, 0, 0);
    step();
    drive(1, 32'h0000_0555, 0, 0);
    step();
    chk("pending.out_valid", N'(out_valid), N'(1'b1));
    drive(0, '0, 0, 1);
    pulse_reset();
    chk_all("reset_present", 1, 0, 32'h0, 32'h0, 0, 8'd0);
    step();
    chk("reset_present_held.cnt", N'(pair_count), N'(0));
    rst_n = 1'b1;

    // 256 back-to-back pairs: exactly 3 cycles each, counter wraps to 0.
    pulses = 0;
    for (int c = 1; c <= 768; c++) begin
      drive(1, N'(c), c[0], 1);
      step();
      if (out_valid) pulses++;
      if (c == 767) begin
        $display("wrap cycle 767: ov=%0b cnt=%0d", out_valid, pair_count);
        chk("wrap_767.out_valid", N'(out_valid), N'(1'b1));
        chk("wrap_767.cnt", N'(pair_count), N'(255));
      end
    end
    $display("wrap cycle 768: ir=%0b ov=%0b cnt=%0d pulses=%0d", in_ready, out_valid, pair_count, pulses);
    chk("wrap.cnt", N'(pair_count), N'(0));
    chk("wrap.in_ready", N'(in_ready), N'(1'b1));
    chk("wrap.out_valid", N'(out_valid), N'(1'b0));
    chk("wrap.pulses", N'(pulses), N'(256));
    chk("wrap.X", X, N'(766));
    chk("wrap.Y", Y, N'(767));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
